// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// control state enum and op-class predicates.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_DIV    = 3'b010;
  localparam logic [2:0] OP_DIVU   = 3'b011;
  localparam logic [2:0] OP_REM    = 3'b100;
  localparam logic [2:0] OP_REMU   = 3'b101;
  localparam logic [2:0] OP_MULHSU = 3'b110;
  localparam logic [2:0] OP_MULHU  = 3'b111;

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for unsigned operands: loads on start,
// then retires one quotient bit per cycle; done holds after the 32nd bit.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvsr;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [XLEN:0]    rem_shift;
  logic [XLEN+1:0]  diff;

  // The shifted partial remainder can reach 33 bits, so the trial subtract
  // is done one bit wider again to expose the borrow.
  assign rem_shift = {rem, quo[XLEN-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dvsr};

  assign done      = busy && (cnt == CNT_W'(XLEN));
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (!diff[XLEN+1]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= rem_shift[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: single-cycle multiplies and special-case
// divides, iterative divider for the rest, one-cycle mdu_ready pulse.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      mdu_op,
  input  logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_ready
);

  state_t state;
  state_t state_d;

  logic                   accept;
  logic                   start;
  logic                   a_sgn;
  logic                   b_sgn;
  logic signed [XLEN:0]   a_ext;
  logic signed [XLEN:0]   b_ext;
  logic signed [2*XLEN-1:0] prod;
  logic                   sdiv;
  logic                   div0;
  logic                   ovf;
  logic [XLEN-1:0]        a_abs;
  logic [XLEN-1:0]        b_abs;
  logic [XLEN-1:0]        fast_res;
  logic [XLEN-1:0]        div_quo;
  logic [XLEN-1:0]        div_rem;
  logic                   div_done;
  logic [XLEN-1:0]        div_res;
  logic                   sel_rem;
  logic                   neg_res;

  // Multiplier: 33-bit extension lets one signed product cover all variants.
  assign a_sgn = (mdu_op == OP_MUL) || (mdu_op == OP_MULH) || (mdu_op == OP_MULHSU);
  assign b_sgn = (mdu_op == OP_MUL) || (mdu_op == OP_MULH);
  assign a_ext = {a_sgn & rs1[XLEN-1], rs1};
  assign b_ext = {b_sgn & rs2[XLEN-1], rs2};
  assign prod  = (2*XLEN)'(a_ext) * (2*XLEN)'(b_ext);

  assign sdiv  = is_signed_div(mdu_op);
  assign div0  = (rs2 == '0);
  assign ovf   = sdiv && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign a_abs = (sdiv && rs1[XLEN-1]) ? -rs1 : rs1;
  assign b_abs = (sdiv && rs2[XLEN-1]) ? -rs2 : rs2;

  always_comb begin
    fast_res = '0;
    case (mdu_op)
      OP_MUL:                        fast_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fast_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fast_res = div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
      OP_REM, OP_REMU:               fast_res = div0 ? rs1 : '0;
      default:                       fast_res = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (mdu_valid) begin
          accept = 1'b1;
          if (is_div_op(mdu_op) && !div0 && !ovf) begin
            start   = 1'b1;
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (div_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  mdu_div #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign div_res = sel_rem ? (neg_res ? -div_rem : div_rem)
                           : (neg_res ? -div_quo : div_quo);

  // Result/ready register; sign-fix controls are captured at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_result <= '0;
      mdu_ready  <= 1'b0;
      sel_rem    <= 1'b0;
      neg_res    <= 1'b0;
    end else begin
      mdu_ready <= 1'b0;
      if (start) begin
        sel_rem <= is_rem_op(mdu_op);
        neg_res <= is_rem_op(mdu_op) ? (sdiv && rs1[XLEN-1])
                                     : (sdiv && (rs1[XLEN-1] ^ rs2[XLEN-1]));
      end else if (accept) begin
        mdu_result <= fast_res;
        mdu_ready  <= 1'b1;
      end else if ((state == DIV_BUSY) && div_done) begin
        mdu_result <= div_res;
        mdu_ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops compared
// against a plain-arithmetic reference model.
module tb_mdu;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  mdu_op;
  logic        mdu_valid;
  logic [31:0] mdu_result;
  logic        mdu_ready;

  int checks   = 0;
  int failures = 0;

  mdu dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .mdu_op     (mdu_op),
    .mdu_valid  (mdu_valid),
    .mdu_result (mdu_result),
    .mdu_ready  (mdu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint p;
    int     sa;
    int     sb;
    logic [63:0] pv;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000: begin p = longint'(sa) * longint'(sb); pv = p; return pv[31:0]; end
      3'b001: begin p = longint'(sa) * longint'(sb); pv = p; return pv[63:32]; end
      3'b110: begin p = longint'(sa) * longint'({32'h0, b}); pv = p; return pv[63:32]; end
      3'b111: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); pv = p; return pv[63:32]; end
      3'b010: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'b011: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b100: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic is_div;
    logic ovf;
    is_div = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    ovf    = ((op == 3'b010) || (op == 3'b100)) && a == 32'h80000000 && b == 32'hFFFFFFFF;
    return (is_div && b != 0 && !ovf) ? 33 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for ready and check
  // latency, value and that ready drops on the following cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    rs1 = a; rs2 = b; mdu_op = op; mdu_valid = 1'b1;
    @(posedge clk);
    #1;
    mdu_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; mdu_op = 3'($urandom);
    lat = 0;
    while (!mdu_ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
    check({tag, "_res"}, mdu_result, exp);
    @(posedge clk);
    #1;
    check({tag, "_rdy_drop"}, {31'b0, mdu_ready}, 32'h0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int pulses;

    rst = 1'b1; rs1 = '0; rs2 = '0; mdu_op = '0; mdu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", mdu_result, 32'h0);
    check("reset_ready", {31'b0, mdu_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_2x10",  3'b000, 32'd2, 32'd10, 32'd20);
    run_op("div_20_4",  3'b010, 32'd20, 32'd4, 32'd5);
    run_op("rem_20_4",  3'b100, 32'd20, 32'd4, 32'd0);
    run_op("remu_23_4", 3'b101, 32'd23, 32'd4, 32'd3);
    run_op("div_m7_2",  3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("rem_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op("mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    run_op("mulhu_max", 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu_m1", 3'b110, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    run_op("div_by0",   3'b010, 32'd77, 32'd0, 32'hFFFFFFFF);
    run_op("remu_by0",  3'b101, 32'h1234, 32'd0, 32'h1234);
    run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_op("divu_big",  3'b011, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_result(op, a, b));
    end

    // Valid held high across idle cycles: two back-to-back multiplies.
    @(negedge clk);
    rs1 = 32'd3; rs2 = 32'd4; mdu_op = 3'b000; mdu_valid = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first", mdu_result, 32'd12);
    rs1 = 32'd5;
    @(posedge clk);
    #1;
    mdu_valid = 1'b0;
    check("b2b_second", mdu_result, 32'd20);
    check("b2b_second_rdy", {31'b0, mdu_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("b2b_rdy_drop", {31'b0, mdu_ready}, 32'h0);

    // MUL request during DIV_BUSY must be dropped.
    @(negedge clk);
    rs1 = 32'd100; rs2 = 32'd7; mdu_op = 3'b011; mdu_valid = 1'b1;
    @(posedge clk);
    #1;
    mdu_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rs1 = 32'd9; rs2 = 32'd9; mdu_op = 3'b000; mdu_valid = 1'b1;
    @(negedge clk);
    mdu_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (mdu_ready) begin
        pulses++;
        check("busy_div_res", mdu_result, 32'd14);
      end
    end
    check("busy_pulse_count", 32'(pulses), 32'd1);

    // Reset during iteration 10 aborts with no pulse afterwards.
    @(negedge clk);
    rs1 = 32'd1000; rs2 = 32'd3; mdu_op = 3'b010; mdu_valid = 1'b1;
    @(posedge clk);
    #1;
    mdu_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_result", mdu_result, 32'h0);
    check("abort_ready", {31'b0, mdu_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (mdu_ready) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);

    run_op("post_abort_mul", 3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- RV32M multiply/divide unit for the rv32im core execute stage.
- Accepts one operation per handshake. Multiplies complete in a single cycle; divides/remainders use an iterative radix-2 restoring divider.
- Returns a 32-bit result with a one-cycle completion pulse.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs1  input  32  operand A (dividend / multiplicand).
- rs2  input  32  operand B (divisor / multiplier).
- mdu_op  input  3  operation select:
  - 000 MUL
  - 001 MULH
  - 010 DIV
  - 011 DIVU
  - 100 REM
  - 101 REMU
  - 110 MULHSU
  - 111 MULHU
- mdu_valid  input  1  request strobe; sampled only when the unit is idle.
- mdu_result  output  32  result; holds its value until the next completion.
- mdu_ready  output  1  one-cycle pulse marking mdu_result valid.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, mdu_result=0, mdu_ready=0, internal registers cleared.
  - Asserting reset mid-operation aborts the operation; no ready pulse follows.
- States: IDLE, DIV_BUSY.
  - IDLE accepts a request when mdu_valid=1.
  - rs1, rs2 and mdu_op are latched at the accepting edge; later input changes have no effect.
- Multiply ops (MUL, MULH, MULHSU, MULHU):
  - Computed combinationally from inputs at the accept edge and registered at that edge.
  - mdu_ready=1 during the following cycle (latency 1). State stays IDLE.
  - Operand extension to 33 bits:
    - MUL and MULH: both signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU: both unsigned.
  - Output is the 64-bit product: MUL returns bits [31:0]; the others return bits [63:32].
- Divide ops (DIV, DIVU, REM, REMU):
  - Signed variants divide absolute values and fix signs at the end:
    - Quotient is negative iff the operand signs differ.
    - Remainder takes the dividend's sign.
  - Divisor zero, resolved at accept, latency 1, no DIV_BUSY:
    - DIV/DIVU return 0xFFFFFFFF.
    - REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF), resolved at accept, latency 1:
    - DIV returns 0x80000000.
    - REM returns 0.
  - Otherwise the unit enters DIV_BUSY and runs 32 iterations, one per cycle:
    - Shift the remainder left with the next dividend bit.
    - Subtract the divisor; keep the difference if it is non-negative.
    - Shift the quotient bit in.
  - After the 32nd iteration: apply the sign fix, register the result, pulse mdu_ready, return to IDLE.
  - Total latency: 33 edges from the accept edge to the edge that raises mdu_ready.
- mdu_valid while in DIV_BUSY is ignored; the request is dropped and the caller must hold or retry.
- A mdu_valid held high in IDLE across consecutive cycles starts a new operation each cycle the unit is idle.
- mdu_ready is never high for more than one consecutive cycle per completed operation.
- mdu_result is unchanged between completions and while busy.

Decomposition:
- Package mdu_pkg holds:
  - the mdu_op encodings as named constants (OP_MUL … OP_MULHU);
  - the state enum (IDLE, DIV_BUSY);
  - helper predicates is_div_op and is_signed_div.
- One sub-module, mdu_div: the iterative unsigned 32-bit divider core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
- Sign handling, special cases and the multiplier stay in mdu.

Test Plan:
- MUL: rs1=2, rs2=10, op=000, mdu_valid pulsed 1 cycle → next cycle mdu_ready=1, mdu_result=20; mdu_ready=0 the cycle after.
- DIV: rs1=20, rs2=4, op=010 → mdu_ready pulses 33 cycles after accept with mdu_result=5.
  - Repeat with REM (op=100) → 0.
  - Repeat with REMU for rs1=23, rs2=4 (op=101) → 3.
- Signed cases:
  - DIV rs1=−7 (0xFFFFFFF9), rs2=2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- Special divides, each ready 1 cycle after accept:
  - DIV by 0 → 0xFFFFFFFF.
  - REMU by 0 with rs1=0x1234 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Busy/abort:
  - mdu_valid for MUL issued during DIV_BUSY → ignored; only the DIV completion pulse appears.
  - rst asserted at iteration 10 → mdu_result=0, mdu_ready=0, and no pulse afterwards.
